spi_host_master: RTL and testbench

SPI_HOST_MASTER -- requirements
Module: spi_host_master

---
 rtl/spi_host_master.sv | 126 ++++++++++++
 tb/tb_spi_host_master.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_host_master.sv
// spi_host_master: mode-0 SPI master that shifts bytes MSB first and holds SS across chained bytes
module spi_host_master #(
  parameter int CLK_DIV = 4,
  parameter int CS_IDLE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       SPI_CLK,
  output logic       SPI_MOSI,
  input  logic       SPI_MISO,
  output logic       SPI_SS
);
  localparam int DW = $clog2(256);
  localparam int BW = $clog2(16);
  typedef enum logic [2:0] {IDLE, SHIFT, WAIT, HOLD, GAP} state_t;
  state_t r_state, w_state;
  logic [DW-1:0] r_div, w_div;
  logic [BW-1:0] r_half, w_half;
  logic [7:0] r_tx, w_tx, r_rx_sh, w_rx_sh, r_rx_data, w_rx_data;
  logic r_last, w_last, r_rx_valid, w_rx_valid, r_sclk, w_sclk, r_mosi, w_mosi, r_ss, w_ss;
  logic w_accept, w_div_end, w_gap_end;
  assign tx_ready  = (r_state == IDLE) || (r_state == WAIT);
  assign busy      = r_state != IDLE;
  assign w_accept  = tx_valid && tx_ready;
  assign w_div_end = r_div == DW'(CLK_DIV - 1);
  assign w_gap_end = r_div == DW'(CS_IDLE - 1);
  assign rx_valid  = r_rx_valid;
  assign rx_data   = r_rx_data;
  assign SPI_CLK   = r_sclk;
  assign SPI_MOSI  = r_mosi;
  assign SPI_SS    = r_ss;
  // next-state and next pin values; the divider doubles as the HOLD and GAP timer
  always_comb begin
    w_state    = r_state;
    w_div      = r_div + DW'(1);
    w_half     = r_half;
    w_tx       = r_tx;
    w_last     = r_last;
    w_rx_sh    = r_rx_sh;
    w_rx_data  = r_rx_data;
    w_rx_valid = 1'b0;
    w_sclk     = r_sclk;
    w_mosi     = r_mosi;
    w_ss       = r_ss;
    case (r_state)
      IDLE, WAIT: begin
        w_div = '0;
        if (w_accept) begin
          w_state = SHIFT;
          w_tx    = tx_data;
          w_last  = tx_last;
          w_mosi  = tx_data[7];
          w_ss    = 1'b0;
          w_half  = '0;
        end
      end
      SHIFT: begin
        if (w_div_end) begin
          w_div  = '0;
          w_sclk = ~r_sclk;
          w_half = r_half == BW'(15) ? r_half : r_half + BW'(1);
          if (!r_sclk) begin
            w_rx_sh = {r_rx_sh[6:0], SPI_MISO};
          end else if (r_half != BW'(15)) begin
            w_mosi = r_tx[6];
            w_tx   = {r_tx[6:0], 1'b0};
          end else begin
            w_rx_valid = 1'b1;
            w_rx_data  = r_rx_sh;
            w_half     = '0;
            w_state    = r_last ? HOLD : WAIT;
          end
        end
      end
      HOLD: begin
        if (w_div_end) begin
          w_div   = '0;
          w_ss    = 1'b1;
          w_state = GAP;
        end
      end
      GAP: begin
        if (w_gap_end) begin
          w_div   = '0;
          w_state = IDLE;
        end
      end
      default: w_state = IDLE;
    endcase
  end
  // register everything so the pins come straight from flops
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_div      <= '0;
      r_half     <= '0;
      r_tx       <= '0;
      r_last     <= 1'b0;
      r_rx_sh    <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_ss       <= 1'b1;
    end else begin
      r_state    <= w_state;
      r_div      <= w_div;
      r_half     <= w_half;
      r_tx       <= w_tx;
      r_last     <= w_last;
      r_rx_sh    <= w_rx_sh;
      r_rx_data  <= w_rx_data;
      r_rx_valid <= w_rx_valid;
      r_sclk     <= w_sclk;
      r_mosi     <= w_mosi;
      r_ss       <= w_ss;
    end
  end
endmodule

// File: tb/tb_spi_host_master.sv
// tb_spi_host_master: directed checks of byte timing, chaining, stalls, reset abort and a slower divider
module tb_spi_host_master;
  logic clk = 1'b0;
  logic rst, tx_valid, tx_last, tx_ready, rx_valid, busy, sclk, mosi, miso, ss, lb;
  logic [7:0] tx_data, rx_data;
  logic tv5, tl5, rdy5, rxv5, busy5, sclk5, mosi5, ss5;
  logic [7:0] td5, rxd5;
  int cyc = 0;
  int n_chk = 0, n_fail = 0;
  int rises [0:127];
  int rise_cnt = 0, rxv_cnt = 0, rxv_cyc = 0, ss_fall_cyc = 0, ss_rise_cyc = 0, ss_fall_cnt = 0, ss_rise_cnt = 0;
  logic [7:0] rxs [0:63];
  logic [7:0] slv_bytes [0:3];
  logic [7:0] slv = 8'h00;
  int sidx = 0, fb = 0;
  logic p_ss = 1'b1, p_sclk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign miso = lb ? mosi : slv[7];
  spi_host_master #(.CLK_DIV(2), .CS_IDLE(4)) u_dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_last(tx_last),
    .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy), .SPI_CLK(sclk), .SPI_MOSI(mosi), .SPI_MISO(miso), .SPI_SS(ss));
  spi_host_master #(.CLK_DIV(5), .CS_IDLE(4)) u_dut5 (
    .clk(clk), .rst(rst), .tx_valid(tv5), .tx_ready(rdy5), .tx_data(td5), .tx_last(tl5),
    .rx_valid(rxv5), .rx_data(rxd5), .busy(busy5), .SPI_CLK(sclk5), .SPI_MOSI(mosi5), .SPI_MISO(mosi5), .SPI_SS(ss5));
  // event recorder and slave model; slave shifts MISO after each SCLK fall
  always @(negedge clk) begin
    p_ss   <= ss;
    p_sclk <= sclk;
    if (p_ss === 1'b1 && ss === 1'b0) begin
      ss_fall_cyc <= cyc;
      ss_fall_cnt <= ss_fall_cnt + 1;
      slv  <= slv_bytes[0];
      sidx <= 1;
      fb   <= 0;
    end else if (p_sclk === 1'b1 && sclk === 1'b0) begin
      if (fb == 7) begin
        slv  <= slv_bytes[sidx & 3];
        sidx <= sidx + 1;
        fb   <= 0;
      end else begin
        slv <= {slv[6:0], 1'b0};
        fb  <= fb + 1;
      end
    end
    if (p_ss === 1'b0 && ss === 1'b1) begin
      ss_rise_cyc <= cyc;
      ss_rise_cnt <= ss_rise_cnt + 1;
    end
    if (p_sclk === 1'b0 && sclk === 1'b1) begin
      rises[rise_cnt & 127] <= cyc;
      rise_cnt <= rise_cnt + 1;
    end
    if (rx_valid === 1'b1) begin
      rxs[rxv_cnt & 63] <= rx_data;
      rxv_cyc <= cyc;
      rxv_cnt <= rxv_cnt + 1;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] d, input logic l, output int t);
    tx_data  = d;
    tx_last  = l;
    tx_valid = 1'b1;
    for (int n = 0; n < 500 && !tx_ready; n++) @(negedge clk);
    if (!tx_ready) check("send_timeout", 0, 1);
    t = cyc;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask
  task automatic wait_ready(output int t);
    for (int n = 0; n < 500 && !tx_ready; n++) @(negedge clk);
    t = cyc;
  endtask
  int t0, t1, t2, br, bv, bsr, bsf, bad, p, nr, fr, lr, te;
  initial begin
    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0; lb = 1'b1;
    tv5 = 1'b0; td5 = 8'h00; tl5 = 1'b0;
    slv_bytes[0] = 8'h00; slv_bytes[1] = 8'h00; slv_bytes[2] = 8'h00; slv_bytes[3] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ss", ss, 1);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_rxv", rx_valid, 0);
    check("rst_rxd", rx_data, 8'h00);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", tx_ready, 1);
    // single looped-back byte
    br = rise_cnt; bv = rxv_cnt;
    send(8'hA5, 1'b1, t0);
    wait_ready(t1);
    check("a5_ss_low", ss_fall_cyc - t0, 1);
    check("a5_rise1", rises[br] - t0, 3);
    check("a5_rise8", rises[br + 7] - t0, 31);
    check("a5_rises", rise_cnt - br, 8);
    check("a5_rxv_cyc", rxv_cyc - t0, 33);
    check("a5_rxd", rxs[bv], 8'hA5);
    check("a5_ss_high", ss_rise_cyc - t0, 35);
    check("a5_ready", t1 - t0, 39);
    // two chained bytes with slave data
    repeat (3) @(negedge clk);
    lb = 1'b0; slv_bytes[0] = 8'h81; slv_bytes[1] = 8'h7E;
    br = rise_cnt; bv = rxv_cnt; bsr = ss_rise_cnt; bsf = ss_fall_cnt;
    send(8'h3C, 1'b0, t0);
    send(8'hC3, 1'b1, t1);
    wait_ready(t2);
    repeat (2) @(negedge clk);
    check("chain_accept2", t1 - t0, 33);
    check("chain_rx1", rxs[bv], 8'h81);
    check("chain_rx2", rxs[bv + 1], 8'h7E);
    check("chain_rises", rise_cnt - br, 16);
    check("chain_ss_rise", ss_rise_cnt - bsr, 1);
    check("chain_ss_fall", ss_fall_cnt - bsf, 1);
    // stall in WAIT
    lb = 1'b1;
    br = rise_cnt; bv = rxv_cnt;
    send(8'h55, 1'b0, t0);
    wait_ready(t1);
    check("stall_wait_cyc", t1 - t0, 33);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (ss !== 1'b0 || sclk !== 1'b0 || tx_ready !== 1'b1 || busy !== 1'b1) bad++;
    end
    check("stall_hold", bad, 0);
    send(8'h96, 1'b1, t2);
    wait_ready(t1);
    repeat (2) @(negedge clk);
    check("stall_rx1", rxs[bv], 8'h55);
    check("stall_rx2", rxs[bv + 1], 8'h96);
    check("stall_rises", rise_cnt - br, 16);
    // tx_valid pulse during SHIFT
    br = rise_cnt; bv = rxv_cnt;
    send(8'h0F, 1'b1, t0);
    repeat (8) @(negedge clk);
    tx_valid = 1'b1; tx_data = 8'hFF; tx_last = 1'b0;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_ready(t1);
    repeat (20) @(negedge clk);
    check("pulse_rises", rise_cnt - br, 8);
    check("pulse_rxv", rxv_cnt - bv, 1);
    check("pulse_rxd", rxs[bv], 8'h0F);
    check("pulse_idle", busy, 0);
    // reset mid-byte
    bv = rxv_cnt;
    send(8'h33, 1'b1, t0);
    for (int n = 0; n < 20 && cyc - t0 < 12; n++) @(negedge clk);
    rst = 1'b1; tx_valid = 1'b1; tx_data = 8'h00; tx_last = 1'b1;
    @(negedge clk);
    check("rst_mid_ss", ss, 1);
    check("rst_mid_sclk", sclk, 0);
    check("rst_mid_busy", busy, 0);
    @(negedge clk);
    check("rst_ignore_valid", busy, 0);
    rst = 1'b0; tx_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_mid_no_rxv", rxv_cnt - bv, 0);
    br = rise_cnt;
    send(8'hE7, 1'b1, t0);
    wait_ready(t1);
    repeat (2) @(negedge clk);
    check("rst_after_rxv", rxv_cnt - bv, 1);
    check("rst_after_rxd", rxs[bv], 8'hE7);
    check("rst_after_rises", rise_cnt - br, 8);
    // CLK_DIV=5 instance
    tv5 = 1'b1; td5 = 8'hAB; tl5 = 1'b1;
    check("div5_ready", rdy5, 1);
    t0 = cyc;
    @(negedge clk);
    tv5 = 1'b0;
    p = 0; nr = 0; fr = -1; lr = -1; te = -1;
    for (int n = 0; n < 300; n++) begin
      if (p == 0 && sclk5 === 1'b1) begin
        nr++;
        if (nr == 1) fr = cyc - t0;
        lr = cyc - t0;
      end
      p = (sclk5 === 1'b1) ? 1 : 0;
      if (rxv5 === 1'b1) begin
        te = cyc - t0;
        break;
      end
      @(negedge clk);
    end
    check("div5_rise1", fr, 6);
    check("div5_rise8", lr, 76);
    check("div5_rises", nr, 8);
    check("div5_end", te, 81);
    check("div5_rxd", rxd5, 8'hAB);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
